mvm_sparse_tx: RTL
==================

Name: mvm_sparse_tx

Overview:
Host-side transmitter that feeds the tt_um_mvm pin interface. It accepts one dense row or vector of N signed 8-bit elements, drops the zero elements, and sends a compressed byte stream into ui_in: a header, then an (index, value) pair for each nonzero element. The accelerator can then skip zero work. The block is used in the FPGA/host harness and in the system-level bench as the stimulus source.

Parameters:
N, 4, elements per row; legal range 1..63 (the count must fit the 6-bit header field).
EW, 8, element width in bits; fixed at 8 for the byte-wide ui_in bus.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  a dense row is present on in_data.
in_ready  output  1  block is idle and can accept a row.
in_data  input  N*EW  element i is in_data[EW*i+EW-1 : EW*i].
out_valid  output  1  out_data holds a valid stream byte.
out_ready  input  1  consumer accepts the byte (driven from a uio_in strobe).
out_data  output  8  stream byte, driven to ui_in.
out_last  output  1  marks the final byte of the frame.
busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and overrides all other inputs.
- Values on reset: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0; state=IDLE; the captured row and the nonzero mask are cleared.
- Frame format:
  - Header byte: {2'b10, cnt[5:0]}, where cnt is the number of nonzero elements.
  - Then, for each nonzero element in ascending index order: an index byte {2'b00, idx[5:0]}, followed by the value byte.
  - An all-zero row gives a header-only frame, 0x80, with out_last=1.
- Handshake:
  - A byte transfers on a cycle with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops without a transfer, except on rst.
  - An input row is accepted on in_valid & in_ready. in_ready=1 only in IDLE.
- FSM:
  - IDLE: on input accept, capture in_data, build mask[i] = (elem_i != 0), and latch cnt = popcount(mask). Go to HDR.
  - HDR: out_valid=1, out_data=header, out_last=(cnt==0). On transfer, go to IDLE if cnt==0, otherwise to IDX.
  - IDX: out_data = index of the lowest set bit of the mask. On transfer, go to VAL.
  - VAL: out_data = that element's value. out_last=1 if it is the last remaining set bit. On transfer, clear that mask bit; go to IDLE if the mask is now zero, otherwise to IDX.
- Latency:
  - Input accepted at cycle t: header valid at t+1.
  - With out_ready held high, a frame with k nonzeros takes 1+2k consecutive output cycles.
  - Last byte transferred at t: in_ready=1 at t+1; the next header is valid at t+2 at the earliest.
- Arithmetic: "nonzero" means any bit set, so 0x80 (-128) is nonzero. Values pass through unmodified.
- Boundaries:
  - in_valid while busy: ignored. in_ready=0, and the upstream source must hold its data.
  - in_data changing during a frame: no effect, because the row is captured at accept.
  - rst mid-frame: out_valid=0 on the next cycle and the frame is abandoned, with no partial bytes after reset. The consumer resyncs on the header tag bits 2'b10.
  - N=1: frames are 0x80 or 0x81,0x00,val.

Decomposition:
- Package mvm_pkg holds:
  - HDR_TAG = 2'b10 and IDX_TAG = 2'b00;
  - MAX_N = 63;
  - the state enum {IDLE, HDR, IDX, VAL};
  - the header-build function.
  The future receive-side unpacker shares this package.
- One sub-module, mvm_first_set (parameter N). Input: the mask. Outputs: the lowest set index (6 bits), found, and last (exactly one bit set). It is combinational and instantiated once.
- Popcount is an inline function in the package.

Test Plan:
1. N=4, row {e0=0x00, e1=0x05, e2=0x00, e3=0xFE}, out_ready=1 → bytes 0x82, 0x01, 0x05, 0x03, 0xFE on consecutive cycles; out_last only on 0xFE; header valid one cycle after accept.
2. All-zero row → single byte 0x80 with out_last=1. in_ready returns the cycle after the transfer; busy pulses for exactly one cycle.
3. Row {1, 2, 3, 0x80} → 0x84, 00, 01, 01, 02, 02, 03, 03, 80 (9 bytes); -128 is treated as nonzero.
4. Scenario 1 repeated with random out_ready (about 50% low) → identical byte sequence; out_data and out_last stable across every stall; no bytes dropped or duplicated.
5. Assert rst after the 2nd byte of scenario 1 → out_valid=0 the next cycle. After release, a new row {0, 0, 0x7F, 0} gives 0x81, 0x02, 0x7F.
6. in_valid held high with two queued rows → the second is accepted only after the first frame's last byte. Its header appears exactly 2 cycles after that last transfer; in_ready=0 throughout the first frame.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared definitions for the sparse row stream (transmit and receive side).
// Tags, limits, FSM states and header/popcount helpers.
package mvm_pkg;

    localparam logic [1:0] HDR_TAG = 2'b10;
    localparam logic [1:0] IDX_TAG = 2'b00;
    localparam int         MAX_N   = 63;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        IDX,
        VAL
    } tx_state_e;

    function automatic logic [7:0] hdr_byte(input logic [5:0] cnt);
        return {HDR_TAG, cnt};
    endfunction

    function automatic logic [5:0] popcount(input logic [MAX_N-1:0] m);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + 6'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mvm_first_set.sv
// Lowest-set-bit finder over the nonzero mask.
// Also flags when exactly one bit remains.
module mvm_first_set #(
    parameter int N = 4
) (
    input  logic [N-1:0] mask_i,
    output logic [5:0]   idx_o,
    output logic         found_o,
    output logic         last_o
);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 6'(i);
        end
    end

    assign found_o = |mask_i;
    assign last_o  = found_o && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/mvm_sparse_tx.sv
// Sparse row transmitter: header, then (index, value) per nonzero element.
// Row is captured at accept; mask bits are retired as values are sent.
module mvm_sparse_tx
    import mvm_pkg::*;
#(
    parameter int N  = 4,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*EW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic          busy
);

    tx_state_e       state_q, state_d;
    logic [N*EW-1:0] row_q, row_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [5:0]      cnt_q, cnt_d;

    logic [N-1:0]    nz;
    logic [5:0]      idx;
    logic            found;
    logic            one_left;
    logic [7:0]      val;

    mvm_first_set #(.N(N)) u_first (
        .mask_i  (mask_q),
        .idx_o   (idx),
        .found_o (found),
        .last_o  (one_left)
    );

    // Per-element nonzero flags and value select for the current index.
    always_comb begin
        nz  = '0;
        val = '0;
        for (int i = 0; i < N; i++) begin
            nz[i] = |in_data[i*EW +: EW];
            if (6'(i) == idx) val = row_q[i*EW +: EW];
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    row_d   = in_data;
                    mask_d  = nz;
                    cnt_d   = popcount(MAX_N'(nz));
                    state_d = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_byte(cnt_q);
                out_last  = (cnt_q == '0);
                if (out_ready) state_d = (cnt_q == '0) ? IDLE : IDX;
            end
            IDX: begin
                out_valid = 1'b1;
                out_data  = {IDX_TAG, idx};
                if (out_ready) state_d = VAL;
            end
            VAL: begin
                out_valid = 1'b1;
                out_data  = val;
                out_last  = one_left;
                if (out_ready) begin
                    mask_d  = mask_q & ~(N'(1) << idx);
                    state_d = (one_left || !found) ? IDLE : IDX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured row and mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
